distance_calculator: RTL and testbench
======================================

Name: distance_calculator

Overview:
- Computes the squared Euclidean distance between a training vector and an input vector, each holding M*N unsigned W-bit elements.
- Elements arrive in bursts of up to MAX_ELEMENTS lanes per handshake.
- Used inside the KNN system: one distance per training sample, returned with that sample's class tag (data_type) for the downstream k-nearest selector.

Parameters:
- M, 6, rows of the feature matrix
- N, 10, columns of the feature matrix; vector length L = M*N
- W, 32, element width in bits (unsigned)
- MAX_ELEMENTS, 16, lanes per burst
- TYPE_W, 2, width of the class tag

Ports:
- clk, input, 1, rising-edge clock
- rst, input, 1, asynchronous active-high reset
- ready, input, 1, one-cycle strobe: the current burst on the data buses is valid
- training_data, input, W*MAX_ELEMENTS, training burst; lane k is at bits [(k+1)*W-1 -: W]
- training_data_type, input, TYPE_W, class tag of the training vector
- input_data, input, W*MAX_ELEMENTS, input-vector burst, same lane layout
- distance, output, 2*W, sum over all L elements of (t-i)^2, modulo 2^(2W)
- data_type, output, TYPE_W, tag latched with the first burst of the current vector
- done, output, 1, high while distance is valid
- data_request, output, 1, one-cycle pulse: ready for the next burst

Behaviour:
- Reset (asynchronous): all outputs go to 0; accumulator, element counter and lane index cleared; state = IDLE. Reset mid-operation aborts the vector. After reset the next ready is treated as the first burst.
- Burst count: B = ceil(L/MAX_ELEMENTS). With the defaults, B = 4, lengths 16/16/16/12. In the last burst, lanes at or beyond the remaining count are ignored. If L <= MAX_ELEMENTS, one burst is the whole vector.
- States:
  - IDLE, WAIT_BURST and DONE: on a sampled ready, register both buses into burst buffers, lane index = 0, go to COMPUTE.
  - On the first burst of a vector (from IDLE or DONE): also clear the accumulator and element counter, latch data_type <= training_data_type, and drop done to 0.
  - COMPUTE: one element per clock. Compute d = |t[k]-i[k]| on W bits (no sign issue), then acc += d*d with a 2W-bit product and a 2W-bit wrapping add.
  - On the cycle that processes the last lane of a burst:
    - If the element counter reaches L: distance <= final acc, done <= 1, go to DONE.
    - Otherwise: data_request <= 1 for exactly one cycle, go to WAIT_BURST.
- Latency: for a burst of b valid lanes sampled at edge E0, the lanes accumulate at E1..Eb, and done or data_request is high after Eb. Full vector (defaults) = 60 compute cycles plus the bus-master gaps.
- ready is ignored in COMPUTE (no capture, no error).
- distance and done hold until the first ready of the next vector. distance keeps its old value until the new result is written.
- data_request is never asserted after the final burst; done is never asserted mid-vector.
- data_type is stable from the first burst until the next vector starts.
- The training and input buses must be stable only at the edge where ready is sampled.

Test Plan:
- L=60, all training=1, input=0, tag=2, 4 bursts -> exactly 3 data_request pulses, done=1, distance=60, data_type=2.
- All training=3, input=5 (reversed operand order) -> distance=240, proving the absolute difference is used.
- Random values in 0..300, 4 consecutive vectors -> each distance matches the reference sum of (t-i)^2; done drops on each new first ready.
- All training=2^32-1, input=0 -> distance = (60*(2^32-1)^2) mod 2^64.
- ready pulsed again during COMPUTE -> ignored; result unchanged from the undisturbed run.
- rst asserted in the middle of the second burst -> outputs are 0 immediately; a fresh full vector afterwards gives the correct distance.

Source files
------------

// File: rtl/distance_calculator.sv
// rtl/distance_calculator.sv - squared Euclidean distance over burst-delivered vectors
module distance_calculator #(
  parameter int M            = 6,
  parameter int N            = 10,
  parameter int W            = 32,
  parameter int MAX_ELEMENTS = 16,
  parameter int TYPE_W       = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ready,
  input  logic [W*MAX_ELEMENTS-1:0] training_data,
  input  logic [TYPE_W-1:0]         training_data_type,
  input  logic [W*MAX_ELEMENTS-1:0] input_data,
  output logic [2*W-1:0]            distance,
  output logic [TYPE_W-1:0]         data_type,
  output logic                      done,
  output logic                      data_request
);

  localparam int L  = M * N;
  localparam int CW = $clog2(L + MAX_ELEMENTS + 1);
  localparam logic [CW-1:0] L_C   = CW'(L);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_ELEMENTS);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_BURST = 2'd1;
  localparam logic [1:0] COMPUTE    = 2'd2;
  localparam logic [1:0] DONE_S     = 2'd3;

  logic [1:0]                state;
  logic [W*MAX_ELEMENTS-1:0] t_buf, i_buf;
  logic [CW-1:0]             lane, burst_len, elem_cnt;
  logic [2*W-1:0]            acc;

  logic [W-1:0]   t_el, i_el, diff;
  logic [2*W-1:0] sq, acc_next;
  logic [CW-1:0]  cnt_next, remaining, next_len;
  logic           first_burst;

  always_comb begin
    t_el        = t_buf[int'(lane)*W +: W];
    i_el        = i_buf[int'(lane)*W +: W];
    diff        = (t_el >= i_el) ? (t_el - i_el) : (i_el - t_el);
    sq          = {{W{1'b0}}, diff} * {{W{1'b0}}, diff};
    acc_next    = acc + sq;
    cnt_next    = elem_cnt + CW'(1);
    first_burst = (state != WAIT_BURST);
    // The first burst of a vector always starts from a full remaining count
    remaining   = first_burst ? L_C : (L_C - elem_cnt);
    next_len    = (remaining > MAX_C) ? MAX_C : remaining;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      t_buf        <= '0;
      i_buf        <= '0;
      lane         <= '0;
      burst_len    <= '0;
      elem_cnt     <= '0;
      acc          <= '0;
      distance     <= '0;
      data_type    <= '0;
      done         <= 1'b0;
      data_request <= 1'b0;
    end else begin
      data_request <= 1'b0;
      case (state)
        IDLE, WAIT_BURST, DONE_S: begin
          if (ready) begin
            t_buf     <= training_data;
            i_buf     <= input_data;
            lane      <= '0;
            burst_len <= next_len;
            state     <= COMPUTE;
            if (first_burst) begin
              acc       <= '0;
              elem_cnt  <= '0;
              data_type <= training_data_type;
              done      <= 1'b0;
            end
          end
        end
        COMPUTE: begin
          acc      <= acc_next;
          elem_cnt <= cnt_next;
          if (lane == burst_len - CW'(1)) begin
            if (cnt_next == L_C) begin
              distance <= acc_next;
              done     <= 1'b1;
              state    <= DONE_S;
            end else begin
              data_request <= 1'b1;
              state        <= WAIT_BURST;
            end
          end else begin
            lane <= lane + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_distance_calculator.sv
// tb/tb_distance_calculator.sv - scoreboard bench for distance_calculator
module tb_distance_calculator;

  localparam int L  = 60;
  localparam int W  = 32;
  localparam int MX = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              ready;
  logic [W*MX-1:0]   training_data;
  logic [1:0]        training_data_type;
  logic [W*MX-1:0]   input_data;
  logic [2*W-1:0]    distance;
  logic [1:0]        data_type;
  logic              done;
  logic              data_request;

  distance_calculator dut (
    .clk                (clk),
    .rst                (rst),
    .ready              (ready),
    .training_data      (training_data),
    .training_data_type (training_data_type),
    .input_data         (input_data),
    .distance           (distance),
    .data_type          (data_type),
    .done               (done),
    .data_request       (data_request)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  t;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] tv [L];
  logic [31:0] iv [L];
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          dreq_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [63:0] model();
    logic [63:0] s;
    logic [31:0] d;
    s = '0;
    for (int e = 0; e < L; e++) begin
      d = (tv[e] >= iv[e]) ? tv[e] - iv[e] : iv[e] - tv[e];
      s = s + 64'(d) * 64'(d);
    end
    return s;
  endfunction

  task automatic garbage();
    for (int k = 0; k < MX; k++) begin
      training_data[k*W +: W] = $urandom;
      input_data[k*W +: W]    = $urandom;
    end
    training_data_type = 2'($urandom);
  endtask

  task automatic monitor();
    logic done_q;
    exp_t e;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (data_request) dreq_total++;
      if (done && !done_q) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = sb.pop_front();
          check("distance", distance, e.d);
          check("data_type", 64'(data_type), 64'(e.t));
        end
      end
      done_q = done;
    end
  endtask

  task automatic send_vector(input logic [1:0] tag, input logic [63:0] exp_d,
                             input bit disturb, input bit abort);
    int n;
    int dreq_start;
    if (!abort) sb.push_back('{d: exp_d, t: tag});
    dreq_start = dreq_total;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      garbage();
      for (int k = 0; k < MX; k++) begin
        if (b*MX + k < L) begin
          training_data[k*W +: W] = tv[b*MX + k];
          input_data[k*W +: W]    = iv[b*MX + k];
        end
      end
      // Later bursts carry a different tag that must not be latched
      training_data_type = (b == 0) ? tag : ~tag;
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      garbage();
      if (b == 0) begin
        check("done_drop", 64'(done), 64'd0);
        check("tag_latch", 64'(data_type), 64'(tag));
      end
      if (disturb && b == 1) begin
        repeat (3) @(negedge clk);
        garbage();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
      if (abort && b == 1) begin
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_distance", distance, 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_type", 64'(data_type), 64'd0);
        check("rst_dreq", 64'(data_request), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      n = 0;
      if (b < 3) begin
        while (!data_request && n < 200) begin @(negedge clk); n++; end
        check("dreq_wait", 64'(data_request), 64'd1);
      end else begin
        while (!done && n < 200) begin @(negedge clk); n++; end
        check("done_wait", 64'(done), 64'd1);
      end
    end
    repeat (2) @(negedge clk);
    check("dreq_count", 64'(dreq_total - dreq_start), 64'd3);
    check("done_hold", 64'(done), 64'd1);
  endtask

  initial begin
    logic [63:0] e;
    rst = 1'b1;
    ready = 1'b0;
    training_data = '0;
    input_data = '0;
    training_data_type = '0;
    fork
      monitor();
    join_none
    repeat (2) @(negedge clk);
    check("reset_distance", distance, 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_type", 64'(data_type), 64'd0);
    check("reset_dreq", 64'(data_request), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < L; i++) begin tv[i] = 32'd1; iv[i] = 32'd0; end
    send_vector(2'd2, 64'd60, 1'b0, 1'b0);

    for (int i = 0; i < L; i++) begin tv[i] = 32'd3; iv[i] = 32'd5; end
    send_vector(2'd1, 64'd240, 1'b0, 1'b0);

    for (int i = 0; i < L; i++) begin tv[i] = 32'hFFFF_FFFF; iv[i] = 32'd0; end
    send_vector(2'd3, 64'd18446743558313476156, 1'b0, 1'b0);

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < L; i++) begin
        tv[i] = $urandom_range(0, 300);
        iv[i] = $urandom_range(0, 300);
      end
      send_vector(2'(v), model(), 1'b0, 1'b0);
    end

    for (int i = 0; i < L; i++) begin
      tv[i] = $urandom_range(0, 300);
      iv[i] = $urandom_range(0, 300);
    end
    e = model();
    send_vector(2'd1, e, 1'b0, 1'b0);
    send_vector(2'd1, e, 1'b1, 1'b0);

    for (int i = 0; i < L; i++) begin tv[i] = 32'd7; iv[i] = 32'd0; end
    send_vector(2'd3, 64'd0, 1'b0, 1'b1);

    for (int i = 0; i < L; i++) begin tv[i] = 32'(i + 1); iv[i] = 32'd0; end
    send_vector(2'd2, 64'd73810, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
